// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : Pipeline writeback register with load-miss wait FSM, retire
//            counter, sticky halt and sticky memory-timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        validIn,
    input  logic [15:0] aluResultIn,
    input  logic [15:0] memDataIn,
    input  logic        memReady,
    input  logic        memToRegIn,
    input  logic        regWriteIn,
    input  logic [2:0]  writeregIn,
    input  logic        haltIn,
    output logic [15:0] writeBackData,
    output logic [2:0]  writereg,
    output logic        regWrite,
    output logic        halt,
    output logic        stall,
    output logic [15:0] retired,
    output logic        err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [3:0] c_TIMEOUT = 4'(TIMEOUT);

    logic [0:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] wbd_q, wbd_d;
    logic [2:0]  wr_q, wr_d;
    logic        rw_q, rw_d;
    logic        halt_q, halt_d;
    logic [15:0] ret_q, ret_d;
    logic        err_q, err_d;

    logic w_load;
    logic w_accept;

    assign w_load = validIn & memToRegIn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            wbd_q   <= 16'h0000;
            wr_q    <= 3'd0;
            rw_q    <= 1'b0;
            halt_q  <= 1'b0;
            ret_q   <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wbd_q   <= wbd_d;
            wr_q    <= wr_d;
            rw_q    <= rw_d;
            halt_q  <= halt_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_load & ~memReady) state_d = S_WAIT;
            S_WAIT:  if (memReady)           state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall    = ~memReady & (((state_q == S_IDLE) & w_load) | (state_q == S_WAIT));
        w_accept = (state_q == S_WAIT) ? memReady : ~(w_load & ~memReady);
    end

    always_comb begin
        wcnt_d = wcnt_q;
        wbd_d  = wbd_q;
        wr_d   = wr_q;
        rw_d   = rw_q;
        halt_d = halt_q;
        ret_d  = ret_q;
        err_d  = err_q;
        if (w_accept) begin
            rw_d   = validIn & regWriteIn & ~halt_q;
            wr_d   = writeregIn;
            wbd_d  = memToRegIn ? memDataIn : aluResultIn;
            wcnt_d = 4'd0;
            if (validIn & ~halt_q) ret_d = ret_q + 16'd1;
            if (validIn & haltIn)  halt_d = 1'b1;
        end else begin
            rw_d = 1'b0;
            if (state_q == S_IDLE) begin
                wcnt_d = 4'd1;
            end else begin
                // Counter saturates so a long miss never wraps back below the limit.
                if (wcnt_q != 4'hF)      wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q >= c_TIMEOUT) err_d  = 1'b1;
            end
        end
    end

    assign writeBackData = wbd_q;
    assign writereg      = wr_q;
    assign regWrite      = rw_q;
    assign halt          = halt_q;
    assign retired       = ret_q;
    assign err           = err_q;

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum number of consecutive WAIT cycles before the block flags an error (range 1-15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 validIn  input  1  a memory-stage instruction is presented this cycle.
REQ-005 aluResultIn  input  16  ALU result from the memory stage.
REQ-006 memDataIn  input  16  data-memory read data; meaningful only when memReady=1.
REQ-007 memReady  input  1  data memory has valid read data this cycle.
REQ-008 memToRegIn  input  1  instruction writes memory data instead of the ALU result.
REQ-009 regWriteIn  input  1  instruction writes the register file.
REQ-010 writeregIn  input  3  destination register number.
REQ-011 haltIn  input  1  instruction is HALT.
REQ-012 writeBackData  output  16  registered data for the register-file write port.
REQ-013 writereg  output  3  registered destination register number.
REQ-014 regWrite  output  1  registered register-file write enable.
REQ-015 halt  output  1  registered, sticky halt indication.
REQ-016 stall  output  1  combinational; upstream holds all inputs stable while it is 1.
REQ-017 retired  output  16  count of retired instructions.
REQ-018 err  output  1  sticky memory-timeout error.

Function
REQ-019 The FSM SHALL have two states: IDLE and WAIT.
REQ-020 A load is defined as validIn=1 & memToRegIn=1.
REQ-021 In IDLE with a load and memReady=0, the FSM SHALL go to WAIT, load the wait counter with 1, and register a bubble with regWrite=0.
REQ-022 In IDLE without that condition, the block SHALL register the instruction on the next edge as follows:
- regWrite <= validIn & regWriteIn & ~halt
- writereg <= writeregIn
- writeBackData <= memToRegIn ? memDataIn : aluResultIn
REQ-023 In WAIT with memReady=1, the block SHALL register the load per REQ-022 and return to IDLE.
REQ-024 In WAIT with memReady=0, the block SHALL remain in WAIT, increment the wait counter, and hold regWrite=0.
REQ-025 stall SHALL equal ~memReady & ((state==IDLE & load) | state==WAIT), with no registered delay.
REQ-026 The instruction latency from capture to register-file write SHALL be exactly 1 cycle after the accepting edge.
REQ-027 A non-memory instruction SHALL never stall.
REQ-028 retired SHALL increment by 1 on every accepting edge with validIn=1, including instructions with regWrite=0.
REQ-029 retired SHALL wrap from 0xFFFF to 0x0000.
REQ-030 When the wait counter reaches TIMEOUT while in WAIT with memReady=0, err SHALL set and stay set until reset; the FSM remains in WAIT.
REQ-031 halt SHALL set on the accepting edge of an instruction with validIn & haltIn, and stay set until reset.
REQ-032 After halt is set, regWrite SHALL be 0 and retired SHALL freeze, regardless of later inputs.
REQ-033 memReady=1 while no load is pending SHALL be ignored.

Reset
REQ-034 On a rising edge with rst=1, the block SHALL force:
- state = IDLE; wait counter = 0
- writeBackData = 0x0000; writereg = 0; regWrite = 0
- halt = 0; retired = 0; err = 0
REQ-035 Reset during WAIT SHALL abandon the pending load with no register-file write.
REQ-036 stall SHALL be 0 in the first cycle after reset unless a load with memReady=0 is presented.

Verification
REQ-037 ALU write: validIn=1, regWriteIn=1, memToRegIn=0, aluResultIn=0x1234, writeregIn=5 -> next cycle writeBackData=0x1234, writereg=5, regWrite=1, stall=0 throughout, retired=1.
REQ-038 Load with 3-cycle miss: load, memReady low 3 cycles then high with memDataIn=0xBEEF -> stall=1 for 3 cycles, regWrite=0 during WAIT, the cycle after memReady writeBackData=0xBEEF with regWrite=1, retired=1.
REQ-039 Timeout: load with memReady held 0 -> err=1 after TIMEOUT (15) WAIT cycles, stall stays 1, regWrite stays 0.
REQ-040 Halt: HALT followed by an ALU write to r3 -> halt=1, no write to r3, retired stops at the HALT's count.
REQ-041 Wrap: preload retired to 0xFFFF via 65535 retirements, retire one more -> retired=0x0000.
REQ-042 Reset mid-WAIT: rst=1 during WAIT, then memReady=1 -> regWrite=0, state IDLE, stall=0, err=0, retired=0.
